// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU producer, the result buffer and its consumer.
// The buffer takes the slave view; whoever drives ALU results and drains the
// buffer takes the master view.
interface alu_result_buffer_if;
    // producer side
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [7:0] in_result;
    logic       in_carry;
    logic       in_zero;
    logic       in_overflow;
    logic       in_negative;
    // consumer side
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_opcode;
    logic [7:0] out_result;
    logic [3:0] out_flags;

    modport master (
        output in_valid, in_opcode, in_result, in_carry, in_zero, in_overflow, in_negative,
        input  in_ready,
        input  out_valid, out_opcode, out_result, out_flags,
        output out_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_result, in_carry, in_zero, in_overflow, in_negative,
        output in_ready,
        output out_valid, out_opcode, out_result, out_flags,
        input  out_ready
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Capture stage behind alu_control: stores {opcode, result, flags} in a small
// show-ahead FIFO and drains it over a valid/ready handshake. Also accumulates
// sticky flags and counts accepted operations for status readout.
module alu_result_buffer #(
    parameter int  DEPTH = 4,
    parameter int  CNT_W = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_buffer_if.slave bus,
    input  logic               sticky_clr,
    output logic [3:0]         sticky_flags,
    output logic [CNT_W-1:0]   op_count,
    output logic [LVL_W-1:0]   level
);
    // entry packing: {opcode[2:0], result[7:0], negative, overflow, zero, carry}
    localparam int                ENTRY_W    = 15;
    localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;
    logic [LVL_W-1:0]   level_next;
    logic [3:0]         sticky_reg;
    logic [3:0]         sticky_next;
    logic [CNT_W-1:0]   count_reg;
    logic [ENTRY_W-1:0] entry_reg [DEPTH];
    logic [DEPTH-1:0]   wr_en;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [3:0]         in_flags;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign in_flags = {bus.in_negative, bus.in_overflow, bus.in_zero, bus.in_carry};
    assign in_entry = {bus.in_opcode, bus.in_result, in_flags};

    // Status comes only from the registered level, so ready/valid never
    // depend combinationally on the opposite side of the buffer.
    assign full          = (level_reg == FULL_LEVEL);
    assign empty         = (level_reg == '0);
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign push          = bus.in_valid && !full;
    assign pop           = bus.out_ready && !empty;

    // One write strobe per storage slot, decoded from the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Storage; cleared on reset so a drained/reset buffer never shows stale data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                entry_reg[i] <= '0;
            end else if (wr_en[i]) begin
                entry_reg[i] <= in_entry;
            end
        end
    end

    // Head is read straight out of registered storage (fall-through), gated
    // to zero while empty so the consumer sees a clean bus.
    assign head_entry     = entry_reg[rd_ptr_reg];
    assign bus.out_opcode = empty ? 3'd0 : head_entry[14:12];
    assign bus.out_result = empty ? 8'd0 : head_entry[11:4];
    assign bus.out_flags  = empty ? 4'd0 : head_entry[3:0];

    // Occupancy: push and pop in the same cycle cancel out.
    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // A push in the clear cycle must survive the clear.
    always_comb begin
        sticky_next = (sticky_clr ? 4'd0 : sticky_reg) | (push ? in_flags : 4'd0);
    end

    // Pointers, occupancy, sticky flags and op counter; pointers wrap naturally
    // because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            sticky_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                count_reg  <= count_reg + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg  <= level_next;
            sticky_reg <= sticky_next;
        end
    end

    assign level        = level_reg;
    assign sticky_flags = sticky_reg;
    assign op_count     = count_reg;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus a random
// soak, all compared against a queue-based reference model.
module tb_alu_result_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             sticky_clr;
    logic [3:0]       sticky_flags;
    logic [CNT_W-1:0] op_count;
    logic [2:0]       level;

    alu_result_buffer_if bus();

    alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
        .op_count     (op_count),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: {opcode, result, flags} entries in arrival order
    logic [14:0]      mq[$];
    logic [3:0]       m_sticky = 4'd0;
    logic [CNT_W-1:0] m_cnt = '0;

    task automatic set_in(input logic v, input logic [2:0] op, input logic [7:0] res, input logic [3:0] fl);
        bus.in_valid = v;
        bus.in_opcode = op;
        bus.in_result = res;
        {bus.in_negative, bus.in_overflow, bus.in_zero, bus.in_carry} = fl;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then settle 1 time unit past the edge for sampling.
    task automatic step();
        logic        push_m;
        logic        pop_m;
        logic [14:0] e;
        @(posedge clk);
        push_m = bus.in_valid && (mq.size() != DEPTH);
        pop_m  = bus.out_ready && (mq.size() != 0);
        e = {bus.in_opcode, bus.in_result, bus.in_negative, bus.in_overflow, bus.in_zero, bus.in_carry};
        if (rst) begin
            mq.delete();
            m_sticky = 4'd0;
            m_cnt = '0;
        end else begin
            if (pop_m) begin
                $display("pop  op=%0d res=%02h flags=%04b", mq[0][14:12], mq[0][11:4], mq[0][3:0]);
                void'(mq.pop_front());
            end
            if (push_m) begin
                $display("push op=%0d res=%02h flags=%04b", e[14:12], e[11:4], e[3:0]);
                mq.push_back(e);
                m_cnt = m_cnt + 1'b1;
            end
            m_sticky = (sticky_clr ? 4'd0 : m_sticky) | (push_m ? e[3:0] : 4'd0);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sticky_clr = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b1, 3'd3, 8'h5A, 4'b1111);
        step();
        step();
        set_in(1'b0, 3'd0, 8'h00, 4'b0000);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (sticky_flags !== 4'd0) begin errors++; $display("FAIL reset_sticky got=%04b exp=0000", sticky_flags); end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        checks++; if (bus.out_result !== 8'd0) begin errors++; $display("FAIL reset_out_result got=%02h exp=00", bus.out_result); end
        rst = 1'b0;
        step();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL post_reset_level got=%0d exp=0", level); end
    endtask

    task automatic test_single_op();
        set_in(1'b1, 3'd0, 8'hFF, 4'b0001);
        step();
        set_in(1'b0, 3'd0, 8'h00, 4'b0000);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_result !== 8'hFF) begin errors++; $display("FAIL single_out_result got=%02h exp=ff", bus.out_result); end
        checks++; if (bus.out_flags !== 4'b0001) begin errors++; $display("FAIL single_out_flags got=%04b exp=0001", bus.out_flags); end
        checks++; if (bus.out_opcode !== 3'd0) begin errors++; $display("FAIL single_out_opcode got=%0d exp=0", bus.out_opcode); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%b exp=0", bus.out_valid); end
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_op_count got=%0d exp=1", op_count); end
    endtask

    task automatic test_fill();
        int  exp_res;
        logic pushing;
        logic popping;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 3'(i), 8'(i), 4'($urandom_range(0, 15)));
            step();
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got=%0d exp=4", level); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
        set_in(1'b1, 3'd5, 8'h05, 4'b0000);
        step();
        step();
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_hold_level got=%0d exp=4", level); end
        checks++; if (op_count !== m_cnt) begin errors++; $display("FAIL fill_hold_count got=%0d exp=%0d", op_count, m_cnt); end
        checks++; if (bus.out_result !== 8'h01) begin errors++; $display("FAIL fill_head_stable got=%02h exp=01", bus.out_result); end
        exp_res = 1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (mq.size() == 0 && !bus.in_valid) break;
            if (mq.size() != 0) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 8'(exp_res)) begin
                    errors++; $display("FAIL fill_drain_order got=%b/%02h exp=1/%02h", bus.out_valid, bus.out_result, 8'(exp_res));
                end
            end
            pushing = bus.in_valid && (mq.size() != DEPTH);
            popping = (mq.size() != 0);
            step();
            if (pushing) bus.in_valid = 1'b0;
            if (popping) exp_res++;
        end
        bus.out_ready = 1'b0;
        checks++; if (exp_res != 6 || level !== 3'd0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL fill_drain_end got=%0d popped level=%0d exp=5 popped level=0", exp_res - 1, level);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 3'($urandom), 8'($urandom), 4'($urandom));
            step();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, 3'($urandom), 8'($urandom), 4'($urandom));
            checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level got=%0d exp=2", level); end
            checks++; if ({bus.out_opcode, bus.out_result, bus.out_flags} !== mq[0]) begin
                errors++; $display("FAIL b2b_head got=%04h exp=%04h", {bus.out_opcode, bus.out_result, bus.out_flags}, mq[0]);
            end
            step();
        end
        set_in(1'b0, 3'd0, 8'h00, 4'b0000);
        for (int k = 0; k < 4 && mq.size() != 0; k++) begin
            checks++; if (bus.out_result !== mq[0][11:4]) begin errors++; $display("FAIL b2b_drain got=%02h exp=%02h", bus.out_result, mq[0][11:4]); end
            step();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_sticky();
        bus.out_ready = 1'b1;
        set_in(1'b0, 3'd0, 8'h00, 4'b0000);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        checks++; if (sticky_flags !== 4'b0000) begin errors++; $display("FAIL sticky_clear got=%04b exp=0000", sticky_flags); end
        set_in(1'b1, 3'd1, 8'h00, 4'b0010);
        step();
        set_in(1'b1, 3'd2, 8'h80, 4'b1000);
        step();
        set_in(1'b0, 3'd0, 8'h00, 4'b0000);
        step();
        checks++; if (sticky_flags !== 4'b1010) begin errors++; $display("FAIL sticky_accum got=%04b exp=1010", sticky_flags); end
        sticky_clr = 1'b1;
        set_in(1'b1, 3'd3, 8'h7F, 4'b0100);
        step();
        sticky_clr = 1'b0;
        set_in(1'b0, 3'd0, 8'h00, 4'b0000);
        checks++; if (sticky_flags !== 4'b0100) begin errors++; $display("FAIL sticky_clr_push got=%04b exp=0100", sticky_flags); end
        step();
        step();
        bus.out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL sticky_drain_level got=%0d exp=0", level); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        set_in(1'b1, 3'd1, 8'h11, 4'b0001); step();
        set_in(1'b1, 3'd2, 8'h22, 4'b0010); step();
        set_in(1'b1, 3'd3, 8'h33, 4'b0100); step();
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL midrst_pre_level got=%0d exp=3", level); end
        rst = 1'b1;
        bus.out_ready = 1'b1;
        set_in(1'b1, 3'd4, 8'h44, 4'b1000);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 3'd0, 8'h00, 4'b0000);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL midrst_level got=%0d exp=0", level); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (op_count !== 16'd0 || sticky_flags !== 4'd0) begin
            errors++; $display("FAIL midrst_status got=%0d/%04b exp=0/0000", op_count, sticky_flags);
        end
        set_in(1'b1, 3'd5, 8'hA5, 4'b0000);
        step();
        set_in(1'b0, 3'd0, 8'h00, 4'b0000);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 8'hA5) begin
            errors++; $display("FAIL midrst_fresh got=%b/%02h exp=1/a5", bus.out_valid, bus.out_result);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_stale got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_random();
        logic [14:0] exp_head;
        for (int k = 0; k < 300; k++) begin
            set_in(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 4'($urandom));
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            sticky_clr = ($urandom_range(0, 7) == 0);
            exp_head = (mq.size() != 0) ? mq[0] : 15'd0;
            checks++; if (level !== 3'(mq.size())) begin errors++; $display("FAIL rand_level got=%0d exp=%0d", level, mq.size()); end
            checks++; if (bus.out_valid !== (mq.size() != 0) || bus.in_ready !== (mq.size() != DEPTH)) begin
                errors++; $display("FAIL rand_handshake got=%b/%b exp=%b/%b", bus.out_valid, bus.in_ready, mq.size() != 0, mq.size() != DEPTH);
            end
            checks++; if ({bus.out_opcode, bus.out_result, bus.out_flags} !== exp_head) begin
                errors++; $display("FAIL rand_head got=%04h exp=%04h", {bus.out_opcode, bus.out_result, bus.out_flags}, exp_head);
            end
            checks++; if (sticky_flags !== m_sticky || op_count !== m_cnt) begin
                errors++; $display("FAIL rand_status got=%04b/%0d exp=%04b/%0d", sticky_flags, op_count, m_sticky, m_cnt);
            end
            step();
        end
        sticky_clr = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 3'd0, 8'h00, 4'b0000);
    endtask

    initial begin
        rst = 1'b1;
        sticky_clr = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 3'd0, 8'h00, 4'b0000);
        test_reset();
        test_single_op();
        test_fill();
        test_back_to_back();
        test_sticky();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
